// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared types and constants for the CPU board I/O blocks:
//   disp_state_t : binary-to-BCD converter FSM states
//   SEG_BLANK    : all segments off ({g..a}, active-low)
//   SEG_TABLE    : active-low {g..a} segment patterns for decimal digits 0..9
// -----------------------------------------------------------------------------
package cpu_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element i holds the pattern for digit i (element 9 is first in the concat).
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD digit to active-low 7-segment decoder.
//   digit : BCD digit 0..9 (10..15 decode to all segments off)
//   seg   : {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import cpu_io_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit < 4'd10) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/rout_display.sv
// -----------------------------------------------------------------------------
// rout_display
// Shows the accumulator output Rout as unsigned decimal on a multiplexed,
// active-low 7-segment display, with leading-zero blanking.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   Rout  : accumulator value (unsigned, n bits)
//   blank : 1 = all anodes off (conversion keeps running)
//   seg   : {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit enables, active-low, an[0] = least-significant digit, registered
//   busy  : high while a conversion is in progress (SHIFT and DONE)
// A sequential shift-add-3 converter refreshes bcd_q whenever Rout differs
// from the last converted value; a free-running prescaler steps the digit scan.
// -----------------------------------------------------------------------------
module rout_display
    import cpu_io_pkg::*;
#(
    parameter int n        = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [n-1:0]      Rout,
    input  logic              blank,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    localparam int BW = DIGITS * 4;                          // BCD field width
    localparam int SW = BW + n;                              // {bcd, bin} shifter width
    localparam int CW = $clog2(n) + 1;                       // shift counter width
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;   // digit index width

    localparam longint unsigned DEC_RANGE = longint'(10) ** DIGITS;
    localparam longint unsigned BIN_RANGE = longint'(1) << n;

    // Enough digits must exist for the largest Rout; this also keeps
    // add-3 carries from ever leaving the top nibble.
    generate
        if (DEC_RANGE <= BIN_RANGE) begin : g_range_check
            $error("rout_display: DIGITS too small for n-bit Rout");
        end
    endgenerate

    disp_state_t       state_q, state_d;
    logic [n-1:0]      cap_q;
    logic [SW-1:0]     sh_q;
    logic [CW-1:0]     cnt_q;
    logic              first_q;
    logic [BW-1:0]     bcd_q;
    logic [SCAN_DIV-1:0] presc_q;
    logic [IW-1:0]     idx_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;

    logic              start;
    logic [BW-1:0]     bcd_adj;
    logic [SW-1:0]     sh_shift;
    logic [DIGITS-1:0] supp;
    logic [3:0]        nib [DIGITS];
    logic [3:0]        cur_nib;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_d;

    // First cycle after reset always converts, so a Rout equal to the reset
    // value of cap_q is still displayed.
    assign start = first_q || (Rout != cap_q);

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(n - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT) || (state_q == DONE);
    end

    // Add-3 correction on every BCD nibble before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            logic [3:0] cur;
            assign cur = sh_q[n + gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (cur >= 4'd5) ? cur + 4'd3 : cur;
        end
    endgenerate

    assign sh_shift = {bcd_adj[BW-2:0], sh_q[n-1:0], 1'b0};

    // Converter datapath; bcd_q only changes in DONE so no partial result is shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b1;
            cap_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cap_q   <= Rout;
                        sh_q    <= {{BW{1'b0}}, Rout};
                        cnt_q   <= '0;
                        first_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_shift;
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    bcd_q <= sh_q[SW-1:n];
                end
                default: ;
            endcase
        end
    end

    // ---------------- digit scan ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (presc_q == {SCAN_DIV{1'b1}}) begin
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    // Digit gi>0 is blanked when it and every higher digit are zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = bcd_q[gi*4 +: 4];
            if (gi == 0) begin : g_lsd
                assign supp[gi] = 1'b0;
            end else begin : g_upper
                assign supp[gi] = (bcd_q[BW-1:gi*4] == '0);
            end
        end
    endgenerate

    assign cur_nib = nib[idx_q];

    bcd_to_seg7 u_dec (
        .digit (cur_nib),
        .seg   (seg_d)
    );

    always_comb begin
        an_d = '1;
        if (!blank && !supp[idx_q]) begin
            an_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_rout_display.sv
// -----------------------------------------------------------------------------
// tb_rout_display
// Directed bench for rout_display (n=8, DIGITS=3, SCAN_DIV=2: 4 cycles/digit).
// -----------------------------------------------------------------------------
module tb_rout_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Rout;
    logic       blank;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rout_display #(
        .n        (8),
        .DIGITS   (3),
        .SCAN_DIV (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Rout  (Rout),
        .blank (blank),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply a value in IDLE and count busy cycles until the converter returns.
    task automatic convert(input logic [7:0] v, output int len);
        Rout = v;
        tick();
        len = 0;
        while (busy && len < 40) begin
            len++;
            tick();
        end
    endtask

    // Align to the start of digit d's scan slot, then check the registered pins
    // (optionally also at the last cycle of the slot).
    task automatic show_digit(input string tag, input int d, input logic [6:0] eseg,
                              input logic [2:0] ean, input bit hold);
        bit found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dut.idx_q == 2'(d) && dut.presc_q == 2'd0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq({tag, "_sync"}, 32'(found), 32'd1);
        tick();
        check_eq({tag, "_seg"}, 32'(seg), 32'(eseg));
        check_eq({tag, "_an"},  32'(an),  32'(ean));
        if (hold) begin
            repeat (3) tick();
            check_eq({tag, "_seg_end"}, 32'(seg), 32'(eseg));
            check_eq({tag, "_an_end"},  32'(an),  32'(ean));
        end
    endtask

    initial begin
        int len;
        int t12, t34, bad, nrel;
        logic [11:0] b;

        // ---- 1: reset, Rout=0 ----
        reset = 1'b1;
        Rout  = 8'd0;
        blank = 1'b0;
        repeat (3) tick();
        check_eq("rst_seg",  32'(seg),  32'h7F);
        check_eq("rst_an",   32'(an),   32'h7);
        check_eq("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();
        len = 0;
        while (busy && len < 40) begin
            len++;
            tick();
        end
        check_eq("t1_busy_len", 32'(len), 32'd9);
        check_eq("t1_bcd", 32'(dut.bcd_q), 32'h000);
        show_digit("t1_d0", 0, 7'h40, 3'b110, 1'b0);
        show_digit("t1_d1", 1, 7'h40, 3'b111, 1'b0);
        show_digit("t1_d2", 2, 7'h40, 3'b111, 1'b0);

        // ---- 2: Rout=255 ----
        convert(8'd255, len);
        check_eq("t2_busy_len", 32'(len), 32'd9);
        check_eq("t2_bcd", 32'(dut.bcd_q), 32'h255);
        show_digit("t2_d0", 0, 7'h12, 3'b110, 1'b1);
        show_digit("t2_d1", 1, 7'h12, 3'b101, 1'b1);
        show_digit("t2_d2", 2, 7'h24, 3'b011, 1'b1);

        // ---- 3: Rout=100 then 7 ----
        convert(8'd100, len);
        check_eq("t3_bcd100", 32'(dut.bcd_q), 32'h100);
        show_digit("t3_d0", 0, 7'h40, 3'b110, 1'b0);
        show_digit("t3_d1", 1, 7'h40, 3'b101, 1'b0);
        show_digit("t3_d2", 2, 7'h79, 3'b011, 1'b0);
        convert(8'd7, len);
        check_eq("t3_bcd7", 32'(dut.bcd_q), 32'h007);
        show_digit("t3_7_d0", 0, 7'h78, 3'b110, 1'b0);
        show_digit("t3_7_d1", 1, 7'h40, 3'b111, 1'b0);
        show_digit("t3_7_d2", 2, 7'h40, 3'b111, 1'b0);

        // ---- 4: Rout=12, changed to 34 in the 3rd SHIFT cycle ----
        t12 = 0;
        t34 = 0;
        bad = 0;
        Rout = 8'd12;
        for (int t = 1; t <= 25; t++) begin
            tick();
            b = dut.bcd_q;
            if (b == 12'h012 && t12 == 0) t12 = t;
            if (b == 12'h034 && t34 == 0) t34 = t;
            if (b != 12'h007 && b != 12'h012 && b != 12'h034) bad++;
            if (t == 3) Rout = 8'd34;
        end
        check_eq("t4_t12", 32'(t12), 32'd10);
        check_eq("t4_t34", 32'(t34), 32'd20);
        check_eq("t4_interm", 32'(bad), 32'd0);

        // ---- 5: reset during SHIFT with Rout=200 ----
        Rout = 8'd200;
        tick();
        tick();
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_seg",  32'(seg),  32'h7F);
        check_eq("t5_rst_an",   32'(an),   32'h7);
        check_eq("t5_rst_busy", 32'(busy), 32'h0);
        check_eq("t5_rst_bcd",  32'(dut.bcd_q), 32'h000);
        tick();
        tick();
        reset = 1'b0;
        nrel = 0;
        while (dut.bcd_q != 12'h200 && nrel < 20) begin
            tick();
            nrel++;
        end
        check_eq("t5_bcd", 32'(dut.bcd_q), 32'h200);
        check_eq("t5_within10", 32'(nrel <= 10), 32'd1);

        // ---- 6: blank=1 with Rout=42 ----
        blank = 1'b1;
        convert(8'd42, len);
        check_eq("t6_busy_len", 32'(len), 32'd9);
        check_eq("t6_bcd", 32'(dut.bcd_q), 32'h042);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (an != 3'b111) bad++;
            tick();
        end
        check_eq("t6_an_blank", 32'(bad), 32'd0);
        blank = 1'b0;
        show_digit("t6_d0", 0, 7'h24, 3'b110, 1'b0);
        show_digit("t6_d1", 1, 7'h19, 3'b101, 1'b0);
        show_digit("t6_d2", 2, 7'h40, 3'b111, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
